// File: rtl/spi_rx_ctrl_if.sv
// spi_rx_ctrl_if: requester/serial-side signal bundle for spi_rx_ctrl.
// master = the controller, slave = requesters plus the serial slave pins.
interface spi_rx_ctrl_if #(
  parameter int unsigned NREQ = 2
);
  localparam int unsigned IW = $clog2(NREQ);

  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] req_len;
  logic              abort;
  logic              miso;
  logic [NREQ-1:0]   gnt;
  logic              cs_b;
  logic              sclk;
  logic [7:0]        data;
  logic              data_vld;
  logic [IW-1:0]     data_id;
  logic              done;
  logic              aborted;

  modport master (
    input  req, req_len, abort, miso,
    output gnt, cs_b, sclk, data, data_vld, data_id, done, aborted
  );

  modport slave (
    output req, req_len, abort, miso,
    input  gnt, cs_b, sclk, data, data_vld, data_id, done, aborted
  );
endinterface

// File: rtl/spi_rx_ctrl.sv
// spi_rx_ctrl: round-robin arbitrated serial byte receiver controller.
// Grants one of NREQ requesters, drives cs_b/sclk, assembles bytes from miso
// and tags each completed byte with the owning requester's index.
// Optional feature macro: SPI_RX_CTRL_LSB_FIRST_EN (LSB-first byte assembly).
module spi_rx_ctrl #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned CLK_DIV = 4
) (
  input logic           clk,
  input logic           rst_b,
  spi_rx_ctrl_if.master bus
);
  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_MID  = DW'(CLK_DIV / 2 - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_END
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              cs_b_q, cs_b_d;
  logic              sclk_q, sclk_d;
  logic [3:0]        len_q, len_d;
  logic [DW-1:0]     div_q, div_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        sh_q, sh_d;
  logic [7:0]        data_q, data_d;
  logic              data_vld_q, data_vld_d;
  logic [IW-1:0]     data_id_q, data_id_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  logic [IW-1:0]     arb_cand;
  logic [IW-1:0]     arb_win;
  logic              arb_hit;
  logic [2:0]        len_sel;
  logic [7:0]        sh_next;

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int unsigned k);
    return IW'((32'(p) + k) % NREQ);
  endfunction

`ifdef SPI_RX_CTRL_LSB_FIRST_EN
  assign sh_next = {bus.miso, sh_q[7:1]};
`else
  assign sh_next = {sh_q[6:0], bus.miso};
`endif

  // Round-robin pick: first requesting index at or after ptr+1, plus its length slice.
  always_comb begin
    arb_cand = '0;
    arb_win  = '0;
    arb_hit  = 1'b0;
    len_sel  = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      arb_cand = wrap_idx(ptr_q, k);
      if (!arb_hit && bus.req[arb_cand]) begin
        arb_hit = 1'b1;
        arb_win = arb_cand;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (arb_win == IW'(i)) len_sel = bus.req_len[3*i +: 3];
    end
  end

  // Next-state and registered-output computation for IDLE/SHIFT/END.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    gnt_d      = gnt_q;
    cs_b_d     = cs_b_q;
    len_d      = len_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sh_d       = sh_q;
    data_d     = data_q;
    data_vld_d = 1'b0;
    data_id_d  = data_id_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_hit) begin
          state_d    = ST_SHIFT;
          ptr_d      = arb_win;
          gnt_d      = NREQ'(1) << arb_win;
          cs_b_d     = 1'b0;
          len_d      = (len_sel == 3'd0) ? 4'd8 : {1'b0, len_sel};
          div_d      = '0;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
        end
      end
      ST_SHIFT: begin
        // abort takes priority over both a completing byte and normal end
        if (bus.abort) begin
          sh_d      = '0;
          bit_cnt_d = '0;
          div_d     = '0;
          state_d   = ST_END;
          gnt_d     = '0;
          cs_b_d    = 1'b1;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else begin
          div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
          if (div_q == DIV_MID) begin
            sh_d      = sh_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              data_d     = sh_next;
              data_vld_d = 1'b1;
              data_id_d  = ptr_q;
              byte_cnt_d = byte_cnt_q + 4'd1;
            end
          end
          if (div_q == DIV_LAST && byte_cnt_q == len_q) begin
            state_d = ST_END;
            div_d   = '0;
            gnt_d   = '0;
            cs_b_d  = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      ST_END: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    sclk_d = (state_d == ST_SHIFT) && (div_d >= DIV_HALF);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= ST_IDLE;
      ptr_q      <= IW'(NREQ - 1);
      gnt_q      <= '0;
      cs_b_q     <= 1'b1;
      sclk_q     <= 1'b0;
      len_q      <= '0;
      div_q      <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      sh_q       <= '0;
      data_q     <= '0;
      data_vld_q <= 1'b0;
      data_id_q  <= '0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      cs_b_q     <= cs_b_d;
      sclk_q     <= sclk_d;
      len_q      <= len_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sh_q       <= sh_d;
      data_q     <= data_d;
      data_vld_q <= data_vld_d;
      data_id_q  <= data_id_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.cs_b     = cs_b_q;
  assign bus.sclk     = sclk_q;
  assign bus.data     = data_q;
  assign bus.data_vld = data_vld_q;
  assign bus.data_id  = data_id_q;
  assign bus.done     = done_q;
  assign bus.aborted  = aborted_q;
endmodule

// File: tb/tb_spi_rx_ctrl.sv
// tb_spi_rx_ctrl: scoreboard bench for spi_rx_ctrl (NREQ=2, CLK_DIV=4).
module tb_spi_rx_ctrl;
  localparam int unsigned NREQ    = 2;
  localparam int unsigned CLK_DIV = 4;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;

  spi_rx_ctrl_if #(.NREQ(NREQ)) bus ();

  spi_rx_ctrl #(.NREQ(NREQ), .CLK_DIV(CLK_DIV)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] exp_q[$];
  bit          exp_done_q[$];
  int vld_cnt = 0, done_cnt = 0;
  int vld_cyc = 0, vld_cyc_prev = 0, done_cyc = 0, grant_cyc = 0;
  logic [NREQ-1:0] prev_gnt = '0;

  // Monitor: pops expected bytes / end flags and checks cs_b and sclk every cycle.
  always @(negedge clk) begin
    logic [15:0] e;
    bit          ea;
    bit          exp_sclk;
    if (!rst_b) begin
      prev_gnt = '0;
    end else begin
      if (bus.gnt != '0 && prev_gnt == '0) grant_cyc = cyc;
      prev_gnt = bus.gnt;
      total++;
      if (bus.cs_b !== (bus.gnt == '0))
        $display("FAIL cs_b_vs_gnt cyc=%0d got cs_b=%b expected %b", cyc, bus.cs_b, (bus.gnt == '0));
      else passed++;
      exp_sclk = (bus.gnt != '0) && (((cyc - grant_cyc) % CLK_DIV) >= CLK_DIV / 2);
      total++;
      if (bus.sclk !== exp_sclk)
        $display("FAIL sclk cyc=%0d got %b expected %b", cyc, bus.sclk, exp_sclk);
      else passed++;
      if (bus.data_vld === 1'b1) begin
        vld_cnt++;
        vld_cyc_prev = vld_cyc;
        vld_cyc = cyc;
        total++;
        if (exp_q.size() == 0) begin
          $display("FAIL data_vld_unexpected cyc=%0d got data=%h expected no pulse", cyc, bus.data);
        end else begin
          e = exp_q.pop_front();
          if ({7'd0, bus.data_id, bus.data} !== e)
            $display("FAIL data_byte cyc=%0d got id=%0d data=%h expected id=%0d data=%h",
                     cyc, bus.data_id, bus.data, e[15:8], e[7:0]);
          else passed++;
        end
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
        total++;
        if (exp_done_q.size() == 0) begin
          $display("FAIL done_unexpected cyc=%0d got done=1 expected 0", cyc);
        end else begin
          ea = exp_done_q.pop_front();
          if (bus.aborted !== ea)
            $display("FAIL aborted_flag cyc=%0d got %b expected %b", cyc, bus.aborted, ea);
          else passed++;
        end
      end else begin
        total++;
        if (bus.aborted !== 1'b0)
          $display("FAIL aborted_idle cyc=%0d got %b expected 0", cyc, bus.aborted);
        else passed++;
      end
    end
  end

  // Waits for a grant, scoreboards the bytes, plays them on miso, optionally aborts.
  task automatic serve(input logic [31:0] payload, input int nbytes, input int id,
                       input bit drop_req, input int abort_bit, output int gcyc);
    int t;
    int start_done;
    logic [7:0] b;
    logic [NREQ-1:0] exp_gnt;
    t = 0;
    gcyc = -1;
    while (bus.gnt === '0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (bus.gnt === '0) begin
      total++;
      $display("FAIL grant_timeout got gnt=%b expected a grant for id %0d", bus.gnt, id);
      return;
    end
    gcyc = cyc;
    if (drop_req) bus.req = '0;
    exp_gnt = NREQ'(1) << id;
    total++;
    if (bus.gnt !== exp_gnt)
      $display("FAIL grant_onehot got gnt=%b expected %b", bus.gnt, exp_gnt);
    else passed++;
    for (int by = 0; by < nbytes; by++)
      if (abort_bit < 0 || (by + 1) * 8 <= abort_bit)
        exp_q.push_back({8'(id), payload[8*by +: 8]});
    exp_done_q.push_back(abort_bit >= 0);
    start_done = done_cnt;
    for (int i = 0; i < nbytes * 8; i++) begin
      b = payload[8*(i/8) +: 8];
`ifdef SPI_RX_CTRL_LSB_FIRST_EN
      bus.miso = b[i % 8];
`else
      bus.miso = b[7 - (i % 8)];
`endif
      if (i == abort_bit) begin
        @(posedge clk);
        #1 bus.abort = 1'b1;
        @(posedge clk);
        #1 bus.abort = 1'b0;
        break;
      end
      repeat (CLK_DIV) @(posedge clk);
      #1;
    end
    t = 0;
    while (done_cnt == start_done && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (done_cnt == start_done) begin
      total++;
      $display("FAIL done_timeout got no done expected a done pulse for id %0d", id);
    end
  endtask

  task automatic test_reset();
    bus.req = '0;
    bus.req_len = '0;
    bus.abort = 1'b0;
    bus.miso = 1'b0;
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.gnt !== '0) $display("FAIL rst_gnt got %b expected 0", bus.gnt); else passed++;
    total++; if (bus.cs_b !== 1'b1) $display("FAIL rst_cs_b got %b expected 1", bus.cs_b); else passed++;
    total++; if (bus.sclk !== 1'b0) $display("FAIL rst_sclk got %b expected 0", bus.sclk); else passed++;
    total++; if (bus.data !== 8'h00) $display("FAIL rst_data got %h expected 00", bus.data); else passed++;
    total++; if (bus.data_vld !== 1'b0) $display("FAIL rst_data_vld got %b expected 0", bus.data_vld); else passed++;
    total++; if (bus.data_id !== '0) $display("FAIL rst_data_id got %0d expected 0", bus.data_id); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL rst_done got %b expected 0", bus.done); else passed++;
    total++; if (bus.aborted !== 1'b0) $display("FAIL rst_aborted got %b expected 0", bus.aborted); else passed++;
    #2 rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int g;
    int v0;
    v0 = vld_cnt;
    bus.req_len = {3'd0, 3'd1};
    bus.req = 2'b01;
    serve(32'h0000_00CA, 1, 0, 1'b1, -1, g);
    total++; if (vld_cnt - v0 !== 1) $display("FAIL single_vld_count got %0d expected 1", vld_cnt - v0); else passed++;
    total++; if (vld_cyc - g !== 30) $display("FAIL single_vld_time got %0d expected 30", vld_cyc - g); else passed++;
    total++; if (done_cyc - g !== 32) $display("FAIL single_done_time got %0d expected 32", done_cyc - g); else passed++;
    total++; if (bus.data !== 8'hCA) $display("FAIL single_data_hold got %h expected CA", bus.data); else passed++;
  endtask

  task automatic test_multi();
    int g;
    int v0;
    int t;
    v0 = vld_cnt;
    bus.req_len = {3'd2, 3'd0};
    bus.req = 2'b10;
    fork
      serve(32'h0000_A73F, 2, 1, 1'b1, -1, g);
      begin
        t = 0;
        while (vld_cnt == v0 && t < 300) begin
          @(negedge clk);
          #1;
          t++;
        end
        repeat (16) @(negedge clk);
        total++;
        if (bus.data !== 8'h3F) $display("FAIL multi_data_between got %h expected 3F", bus.data);
        else passed++;
      end
    join
    total++; if (vld_cnt - v0 !== 2) $display("FAIL multi_vld_count got %0d expected 2", vld_cnt - v0); else passed++;
    total++; if (vld_cyc - vld_cyc_prev !== 32) $display("FAIL multi_vld_spacing got %0d expected 32", vld_cyc - vld_cyc_prev); else passed++;
    total++; if (bus.data_id !== 1'b1) $display("FAIL multi_data_id got %0d expected 1", bus.data_id); else passed++;
  endtask

  task automatic test_round_robin();
    int g0, g1, g2;
    bus.req_len = {3'd1, 3'd1};
    bus.req = 2'b11;
    serve(32'h0000_0096, 1, 0, 1'b0, -1, g0);
    serve(32'h0000_005B, 1, 1, 1'b0, -1, g1);
    serve(32'h0000_00E1, 1, 0, 1'b1, -1, g2);
    total++; if (g1 - g0 !== 34) $display("FAIL rr_spacing_01 got %0d expected 34", g1 - g0); else passed++;
    total++; if (g2 - g1 !== 34) $display("FAIL rr_spacing_12 got %0d expected 34", g2 - g1); else passed++;
  endtask

  task automatic test_abort();
    int g;
    int v0;
    v0 = vld_cnt;
    bus.req_len = {3'd0, 3'd2};
    bus.req = 2'b01;
    serve(32'h0000_D24B, 2, 0, 1'b1, 12, g);
    total++; if (vld_cnt - v0 !== 1) $display("FAIL abort12_vld_count got %0d expected 1", vld_cnt - v0); else passed++;
    total++; if (bus.data !== 8'h4B) $display("FAIL abort12_data got %h expected 4B", bus.data); else passed++;
    total++; if (done_cyc - g !== 50) $display("FAIL abort12_done_time got %0d expected 50", done_cyc - g); else passed++;
  endtask

  task automatic test_abort_8th();
    int g;
    int v0;
    v0 = vld_cnt;
    bus.req_len = {3'd0, 3'd1};
    bus.req = 2'b01;
    serve(32'h0000_003C, 1, 0, 1'b1, 7, g);
    total++; if (vld_cnt - v0 !== 0) $display("FAIL abort8_vld_count got %0d expected 0", vld_cnt - v0); else passed++;
    total++; if (bus.data !== 8'h4B) $display("FAIL abort8_data got %h expected 4B", bus.data); else passed++;
    total++; if (done_cyc - g !== 30) $display("FAIL abort8_done_time got %0d expected 30", done_cyc - g); else passed++;
  endtask

  task automatic test_reset_mid();
    int g;
    int t;
    bus.req_len = {3'd0, 3'd2};
    bus.req = 2'b01;
    bus.miso = 1'b1;
    t = 0;
    while (bus.gnt === '0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    bus.req = '0;
    total++; if (bus.gnt !== 2'b01) $display("FAIL rmid_grant got %b expected 01", bus.gnt); else passed++;
    repeat (20) @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    total++; if (bus.cs_b !== 1'b1) $display("FAIL rmid_cs_b got %b expected 1", bus.cs_b); else passed++;
    total++; if (bus.sclk !== 1'b0) $display("FAIL rmid_sclk got %b expected 0", bus.sclk); else passed++;
    total++; if (bus.gnt !== '0) $display("FAIL rmid_gnt got %b expected 0", bus.gnt); else passed++;
    total++; if (bus.data !== 8'h00) $display("FAIL rmid_data got %h expected 00", bus.data); else passed++;
    total++; if (bus.done !== 1'b0) $display("FAIL rmid_done got %b expected 0", bus.done); else passed++;
    repeat (2) @(negedge clk);
    #2 rst_b = 1'b1;
    bus.req_len = {3'd1, 3'd1};
    bus.req = 2'b11;
    serve(32'h0000_0071, 1, 0, 1'b1, -1, g);
    total++; if (bus.data !== 8'h71) $display("FAIL rmid_after_data got %h expected 71", bus.data); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_round_robin();
    test_abort();
    test_abort_8th();
    test_reset_mid();
    repeat (4) @(negedge clk);
    total++;
    if (exp_q.size() != 0 || exp_done_q.size() != 0)
      $display("FAIL scoreboard_drain got %0d bytes %0d ends pending expected 0", exp_q.size(), exp_done_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no completion expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
